// File: rtl/led_frame_scheduler.sv
// Walks every LED of the cube in chain order, feeds GRB words to the serializer, then latches.
// Optional FRAME_AUTO_REFRESH_EN: re-arm the pending flag after each latch gap for continuous refresh.
module led_frame_scheduler #(
  parameter int unsigned NUM_FACES     = 6,
  parameter int unsigned LEDS_PER_FACE = 64,
  parameter int unsigned LATCH_CYCLES  = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  face_mask,
  output logic        pix_req,
  output logic [2:0]  pix_face,
  output logic [5:0]  pix_index,
  input  logic [23:0] pix_data,
  output logic        ser_valid,
  output logic [23:0] ser_data,
  input  logic        ser_ready,
  input  logic        ser_idle,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned LatchW = $clog2(LATCH_CYCLES + 1);
  localparam logic [2:0] LastFace = 3'(NUM_FACES - 1);
  localparam logic [5:0] LastLed = 6'(LEDS_PER_FACE - 1);
  localparam logic [LatchW-1:0] LatchLast = LatchW'(LATCH_CYCLES - 1);
  localparam logic [LatchW-1:0] LatchPenult = LatchW'(LATCH_CYCLES - 2);
  localparam logic LatchOne = (LATCH_CYCLES == 1);

`ifdef FRAME_AUTO_REFRESH_EN
  localparam logic AutoRefresh = 1'b1;
`else
  localparam logic AutoRefresh = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle, StFetch, StWait, StSend, StNext, StDrain, StLatch
  } state_e;

  state_e            r_state;
  logic [5:0]        r_mask;
  logic [2:0]        r_face;
  logic [5:0]        r_led;
  logic [23:0]       r_hold;
  logic [LatchW-1:0] r_latch;
  logic              r_pending;
  logic              r_pix_req;
  logic              r_ser_valid;
  logic              r_busy;
  logic              r_frame_done;

  logic [2:0] w_next_face;
  logic       w_cur_en;

  assign w_next_face = r_face + 3'd1;
  assign w_cur_en    = r_mask[r_face];

  assign pix_req    = r_pix_req;
  assign pix_face   = r_face;
  assign pix_index  = r_led;
  assign ser_valid  = r_ser_valid;
  assign ser_data   = r_hold;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

  // Outputs are registered from the next state, so pix_req rises together with FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_mask       <= '0;
      r_face       <= '0;
      r_led        <= '0;
      r_hold       <= '0;
      r_latch      <= '0;
      r_pending    <= 1'b0;
      r_pix_req    <= 1'b0;
      r_ser_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (start && (r_state != StIdle)) r_pending <= 1'b1;
      case (r_state)
        StIdle: begin
          if (start || r_pending) begin
            r_state   <= StFetch;
            r_mask    <= face_mask;
            r_face    <= '0;
            r_led     <= '0;
            r_pending <= 1'b0;
            r_pix_req <= face_mask[0];
            r_busy    <= 1'b1;
          end
        end
        StFetch: begin
          r_pix_req <= 1'b0;
          r_state   <= StWait;
        end
        StWait: begin
          r_hold      <= w_cur_en ? pix_data : 24'h0;
          r_ser_valid <= 1'b1;
          r_state     <= StSend;
        end
        StSend: begin
          if (ser_ready) begin
            r_ser_valid <= 1'b0;
            r_state     <= StNext;
          end
        end
        StNext: begin
          if (r_led == LastLed) begin
            r_led <= '0;
            if (r_face == LastFace) begin
              r_state <= StDrain;
            end else begin
              r_face    <= w_next_face;
              r_pix_req <= r_mask[w_next_face];
              r_state   <= StFetch;
            end
          end else begin
            r_led     <= r_led + 6'd1;
            r_pix_req <= w_cur_en;
            r_state   <= StFetch;
          end
        end
        StDrain: begin
          if (ser_idle) begin
            r_latch      <= '0;
            r_frame_done <= LatchOne;
            r_state      <= StLatch;
          end
        end
        StLatch: begin
          // frame_done is raised one count early so it lands on the final latch cycle.
          if (r_latch == LatchLast) begin
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= StIdle;
            if (AutoRefresh) r_pending <= 1'b1;
          end else begin
            r_latch      <= r_latch + LatchW'(1);
            r_frame_done <= (r_latch == LatchPenult);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler: ordering, masking, back-pressure, drain/latch, pending, reset.
module tb_led_frame_scheduler;

  localparam int L = 2000;

  logic        clk = 1'b0;
  logic        reset, start, ser_ready, ser_idle;
  logic [5:0]  face_mask;
  logic [23:0] pix_data;
  logic        pix_req, ser_valid, busy, frame_done;
  logic [2:0]  pix_face;
  logic [5:0]  pix_index;
  logic [23:0] ser_data;

  led_frame_scheduler #(
    .NUM_FACES    (6),
    .LEDS_PER_FACE(64),
    .LATCH_CYCLES (L)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .face_mask (face_mask),
    .pix_req   (pix_req),
    .pix_face  (pix_face),
    .pix_index (pix_index),
    .pix_data  (pix_data),
    .ser_valid (ser_valid),
    .ser_data  (ser_data),
    .ser_ready (ser_ready),
    .ser_idle  (ser_idle),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [23:0] xfer_q[$];
  logic [8:0]  pr_q[$];
  int          pr_cyc_q[$];
  int          fd_cyc_q[$];
  int          fd_cnt, stab_err, sv_cnt, xfer_cyc;
  logic        stall_q;
  logic [23:0] stall_data;

  function automatic logic [23:0] pat(input logic [2:0] f, input logic [5:0] i);
    return {8'hC3, 5'd0, f, 2'd0, i};
  endfunction

  // Masked faces must return 0, so a stray read of this value is detectable.
  always @(posedge clk) pix_data <= pix_req ? pat(pix_face, pix_index) : 24'hBADBAD;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      if (ser_valid && ser_ready) begin
        xfer_q.push_back(ser_data);
        xfer_cyc = cyc;
      end
      if (ser_valid) sv_cnt++;
      if (pix_req) begin
        pr_q.push_back({pix_face, pix_index});
        pr_cyc_q.push_back(cyc);
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc_q.push_back(cyc);
      end
      if (stall_q && (!ser_valid || ser_data !== stall_data)) stab_err++;
      stall_q    = ser_valid && !ser_ready;
      stall_data = ser_data;
    end
  end

  task automatic clear_log();
    xfer_q.delete();
    pr_q.delete();
    pr_cyc_q.delete();
    fd_cyc_q.delete();
    fd_cnt   = 0;
    stab_err = 0;
    sv_cnt   = 0;
    stall_q  = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Number of transferred words (from index base) that differ from the expected frame.
  function automatic int data_errs(input logic [5:0] m, input int base);
    int e = 0;
    for (int k = 0; k < 384; k++) begin
      logic [2:0]  f = 3'(k / 64);
      logic [5:0]  i = 6'(k % 64);
      logic [23:0] exp_w = m[f] ? pat(f, i) : 24'h0;
      if (base + k >= xfer_q.size()) e++;
      else if (xfer_q[base + k] !== exp_w) e++;
    end
    return e;
  endfunction

  function automatic int order_errs(input logic [5:0] m, input int base);
    int e = 0;
    int j = base;
    for (int k = 0; k < 384; k++) begin
      logic [2:0] f = 3'(k / 64);
      logic [5:0] i = 6'(k % 64);
      if (m[f]) begin
        if (j >= pr_q.size()) e++;
        else if (pr_q[j] !== {f, i}) e++;
        j++;
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; face_mask = 6'h0; ser_ready = 1'b1; ser_idle = 1'b1;
    clear_log();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({pix_req, ser_valid, busy, frame_done} !== 4'b0)
      $display("FAIL reset_ctrl: got %b, expected 0000", {pix_req, ser_valid, busy, frame_done});
    else n_pass++;
    n_checks++;
    if ({pix_face, pix_index, ser_data} !== 33'h0)
      $display("FAIL reset_data: got %h, expected 0", {pix_face, pix_index, ser_data});
    else n_pass++;
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || pr_q.size() != 0)
      $display("FAIL reset_idle: busy=%b reqs=%0d, expected busy=0 reqs=0", busy, pr_q.size());
    else n_pass++;
  endtask

  task automatic test_full_frame();
    clear_log();
    face_mask = 6'h3F;
    pulse_start();
    @(negedge clk);
    n_checks++;
    if (pix_req !== 1'b1 || busy !== 1'b1 || {pix_face, pix_index} !== 9'h0)
      $display("FAIL first_fetch: req=%b busy=%b addr=%h, expected 1 1 000",
               pix_req, busy, {pix_face, pix_index});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (pix_req !== 1'b0 || ser_valid !== 1'b0)
      $display("FAIL first_wait: req=%b valid=%b, expected 0 0", pix_req, ser_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ser_valid !== 1'b1 || ser_data !== pat(3'd0, 6'd0))
      $display("FAIL first_send: valid=%b data=%h, expected 1 %h", ser_valid, ser_data,
               pat(3'd0, 6'd0));
    else n_pass++;
    for (int c = 0; c < 6000 && fd_cnt < 1; c++) @(posedge clk);
    n_checks++;
    if (fd_cnt < 1) $display("FAIL full_timeout: frame_done count %0d, expected 1", fd_cnt);
    else n_pass++;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (fd_cnt != 1 || busy !== 1'b0)
      $display("FAIL full_done: frames=%0d busy=%b, expected 1 0", fd_cnt, busy);
    else n_pass++;
    n_checks++;
    if (xfer_q.size() != 384 || pr_q.size() != 384)
      $display("FAIL full_counts: xfers=%0d reqs=%0d, expected 384 384", xfer_q.size(), pr_q.size());
    else n_pass++;
    n_checks++;
    if (data_errs(6'h3F, 0) != 0 || order_errs(6'h3F, 0) != 0)
      $display("FAIL full_data: data errs %0d order errs %0d, expected 0 0",
               data_errs(6'h3F, 0), order_errs(6'h3F, 0));
    else n_pass++;
  endtask

  task automatic test_face_mask();
    clear_log();
    face_mask = 6'b000101;
    pulse_start();
    repeat (10) @(posedge clk);
    #1 face_mask = 6'h3F;
    for (int c = 0; c < 6000 && fd_cnt < 1; c++) @(posedge clk);
    n_checks++;
    if (fd_cnt != 1) $display("FAIL mask_timeout: frames %0d, expected 1", fd_cnt);
    else n_pass++;
    n_checks++;
    if (pr_q.size() != 128) $display("FAIL mask_reqs: got %0d strobes, expected 128", pr_q.size());
    else n_pass++;
    n_checks++;
    if (xfer_q.size() != 384 || data_errs(6'b000101, 0) != 0 || order_errs(6'b000101, 0) != 0)
      $display("FAIL mask_data: xfers=%0d data errs %0d order errs %0d, expected 384 0 0",
               xfer_q.size(), data_errs(6'b000101, 0), order_errs(6'b000101, 0));
    else n_pass++;
  endtask

  task automatic test_random_ready();
    clear_log();
    face_mask = 6'b110010;
    pulse_start();
    for (int c = 0; c < 15000 && fd_cnt < 1; c++) begin
      @(posedge clk); #1 ser_ready = 1'($urandom_range(0, 1));
    end
    ser_ready = 1'b1;
    n_checks++;
    if (fd_cnt != 1) $display("FAIL rr_timeout: frames %0d, expected 1", fd_cnt);
    else n_pass++;
    n_checks++;
    if (stab_err != 0) $display("FAIL rr_stable: %0d unstable stalls, expected 0", stab_err);
    else n_pass++;
    n_checks++;
    if (xfer_q.size() != 384 || data_errs(6'b110010, 0) != 0)
      $display("FAIL rr_data: xfers=%0d errs=%0d, expected 384 0",
               xfer_q.size(), data_errs(6'b110010, 0));
    else n_pass++;
  endtask

  task automatic test_drain_hold();
    int idle_cyc, sv_at_last;
    clear_log();
    face_mask = 6'h01;
    ser_idle  = 1'b0;
    pulse_start();
    for (int c = 0; c < 6000 && xfer_q.size() < 384; c++) begin
      @(posedge clk); #1;
    end
    sv_at_last = sv_cnt;
    repeat (99) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || fd_cnt != 0 || xfer_q.size() != 384)
      $display("FAIL drain_wait: busy=%b frames=%0d xfers=%0d, expected 1 0 384",
               busy, fd_cnt, xfer_q.size());
    else n_pass++;
    @(posedge clk); #1 ser_idle = 1'b1;
    idle_cyc = cyc;
    for (int c = 0; c < 3000 && fd_cnt < 1; c++) @(posedge clk);
    n_checks++;
    if (fd_cyc_q.size() != 1 || fd_cyc_q[0] - idle_cyc != L)
      $display("FAIL drain_latch: frames=%0d delay=%0d, expected 1 %0d", fd_cyc_q.size(),
               (fd_cyc_q.size() > 0) ? fd_cyc_q[0] - idle_cyc : -1, L);
    else n_pass++;
    n_checks++;
    if (sv_cnt != sv_at_last)
      $display("FAIL drain_valid: %0d valid cycles after last transfer, expected 0",
               sv_cnt - sv_at_last);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_log();
    face_mask = 6'h3F;
    pulse_start();
    repeat (50) @(posedge clk);
    pulse_start();
    repeat (500) @(posedge clk);
    pulse_start();
    repeat (1000) @(posedge clk);
    pulse_start();
    for (int c = 0; c < 12000 && fd_cnt < 2; c++) @(posedge clk);
    repeat (100) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (fd_cnt != 2 || busy !== 1'b0)
      $display("FAIL b2b_frames: frames=%0d busy=%b, expected 2 0", fd_cnt, busy);
    else n_pass++;
    n_checks++;
    if (pr_q.size() != 768 || xfer_q.size() != 768)
      $display("FAIL b2b_counts: reqs=%0d xfers=%0d, expected 768 768", pr_q.size(), xfer_q.size());
    else n_pass++;
    n_checks++;
    if (pr_cyc_q.size() < 385 || fd_cyc_q.size() < 1 || pr_cyc_q[384] != fd_cyc_q[0] + 2)
      $display("FAIL b2b_restart: second fetch at %0d, expected %0d",
               (pr_cyc_q.size() > 384) ? pr_cyc_q[384] : -1,
               (fd_cyc_q.size() > 0) ? fd_cyc_q[0] + 2 : -1);
    else n_pass++;
    n_checks++;
    if (data_errs(6'h3F, 384) != 0 || order_errs(6'h3F, 384) != 0)
      $display("FAIL b2b_data: second frame data errs %0d order errs %0d, expected 0 0",
               data_errs(6'h3F, 384), order_errs(6'h3F, 384));
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    face_mask = 6'h3F;
    pulse_start();
    for (int c = 0; c < 6000 && xfer_q.size() < 200; c++) begin
      @(posedge clk); #1;
    end
    pulse_start();
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({pix_req, ser_valid, busy, frame_done} !== 4'b0 || {pix_face, pix_index, ser_data} !== 33'h0)
      $display("FAIL mid_reset_async: ctrl=%b data=%h, expected 0000 0",
               {pix_req, ser_valid, busy, frame_done}, {pix_face, pix_index, ser_data});
    else n_pass++;
    repeat (3) @(posedge clk);
    clear_log();
    #1 reset = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (pr_q.size() != 0 || fd_cnt != 0 || busy !== 1'b0)
      $display("FAIL mid_reset_quiet: reqs=%0d frames=%0d busy=%b, expected 0 0 0",
               pr_q.size(), fd_cnt, busy);
    else n_pass++;
    pulse_start();
    for (int c = 0; c < 6000 && fd_cnt < 1; c++) @(posedge clk);
    n_checks++;
    if (fd_cnt != 1 || xfer_q.size() != 384 || data_errs(6'h3F, 0) != 0 || order_errs(6'h3F, 0) != 0)
      $display("FAIL mid_reset_restart: frames=%0d xfers=%0d errs=%0d, expected 1 384 0",
               fd_cnt, xfer_q.size(), data_errs(6'h3F, 0) + order_errs(6'h3F, 0));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_face_mask();
    test_random_ready();
    test_drain_hold();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
